shift_seq: RTL and testbench

//  Multi-cycle sequential shifter/rotator: consumes a carry flag and performs N single-bit steps.

---
 rtl/shift_seq_pkg.sv | 21 ++
 rtl/shift_step.sv | 36 +++
 rtl/shift_seq.sv | 122 ++++++++++++
 tb/tb_shift_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the sequential shifter: widths, op codes and FSM states.
package shift_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    SHOP_SHL = 2'b00,
    SHOP_SHR = 2'b01,
    SHOP_RCL = 2'b10,
    SHOP_RCR = 2'b11
  } shop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_FIN   = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit step: one shift or rotate-through-carry of {carry, value}.
// Ports:
//   op          - operation (SHL/SHR/RCL/RCR)
//   value       - current data word
//   carry       - current carry flag
//   value_nxt_c - data word after one step
//   carry_nxt_c - carry after one step (the bit shifted out)
module shift_step
  import shift_seq_pkg::*;
(
  input  shop_e             op,
  input  logic [DATA_W-1:0] value,
  input  logic              carry,
  output logic [DATA_W-1:0] value_nxt_c,
  output logic              carry_nxt_c
);

  logic shift_left;
  logic fill;

  // Direction select plus serial-fill select: rotates feed the old carry in, shifts feed zero.
  always_comb begin
    shift_left  = (op == SHOP_SHL) || (op == SHOP_RCL);
    fill        = ((op == SHOP_RCL) || (op == SHOP_RCR)) ? carry : 1'b0;
    value_nxt_c = value;
    carry_nxt_c = carry;
    if (shift_left) begin
      value_nxt_c = {value[DATA_W-2:0], fill};
      carry_nxt_c = value[DATA_W-1];
    end else begin
      value_nxt_c = {fill, value[DATA_W-1:1]};
      carry_nxt_c = value[0];
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter/rotator beside the ALU: START loads operand and carry, then one
// bit step per clock for COUNT steps; DONE pulses for one cycle with the result valid.
// Ports:
//   CLK, RST_bar - rising-edge clock, asynchronous active-low reset
//   START        - load request, honoured in IDLE or FIN
//   OP_SEL       - 00 SHL, 01 SHR, 10 RCL, 11 RCR
//   COUNT        - number of single-bit steps (0..7)
//   VALUE_IN     - operand, latched on load
//   CARRY_IN     - carry, latched on load
//   VALUE_OUT    - working/result register
//   CARRY_OUT    - working/result carry
//   BUSY         - high while shifting
//   DONE         - one-cycle result-valid pulse
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic              CLK,
  input  logic              RST_bar,
  input  logic              START,
  input  logic [OP_W-1:0]   OP_SEL,
  input  logic [CNT_W-1:0]  COUNT,
  input  logic [DATA_W-1:0] VALUE_IN,
  input  logic              CARRY_IN,
  output logic [DATA_W-1:0] VALUE_OUT,
  output logic              CARRY_OUT,
  output logic              BUSY,
  output logic              DONE
);

  // Propagation delays only annotate the discrete build; the RTL is zero-delay.
  if ((DELAY_RISE < 0) || (DELAY_FALL < 0)) begin : g_bad_delay
    $error("shift_seq: propagation delays must be non-negative");
  end

  state_e             state_q, state_d;
  shop_e              op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  value_q, value_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DATA_W-1:0]  step_value_c;
  logic               step_carry_c;

  shift_step u_step (
    .op          (op_q),
    .value       (value_q),
    .carry       (carry_q),
    .value_nxt_c (step_value_c),
    .carry_nxt_c (step_carry_c)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state_q <= ST_IDLE;
      op_q    <= SHOP_SHL;
      cnt_q   <= '0;
      value_q <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    carry_d = carry_q;

    unique case (state_q)
      ST_IDLE, ST_FIN: begin
        if (START) begin
          value_d = VALUE_IN;
          carry_d = CARRY_IN;
          op_d    = shop_e'(OP_SEL);
          cnt_d   = COUNT;
          state_d = (COUNT == '0) ? ST_FIN : ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        value_d = step_value_c;
        carry_d = step_carry_c;
        // Saturate at zero; the step that takes cnt from 1 to 0 is the last one.
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_FIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags registered from the next state so they align with it.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_FIN);
  end

  assign VALUE_OUT = value_q;
  assign CARRY_OUT = carry_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

  logic       CLK;
  logic       RST_bar;
  logic       START;
  logic [1:0] OP_SEL;
  logic [2:0] COUNT;
  logic [7:0] VALUE_IN;
  logic       CARRY_IN;
  logic [7:0] VALUE_OUT;
  logic       CARRY_OUT;
  logic       BUSY;
  logic       DONE;

  int n_checks = 0;
  int n_fail   = 0;

  shift_seq #(.DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .CLK       (CLK),
    .RST_bar   (RST_bar),
    .START     (START),
    .OP_SEL    (OP_SEL),
    .COUNT     (COUNT),
    .VALUE_IN  (VALUE_IN),
    .CARRY_IN  (CARRY_IN),
    .VALUE_OUT (VALUE_OUT),
    .CARRY_OUT (CARRY_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] op;
    logic [2:0] cnt;
    logic [7:0] val;
    logic       cin;
    logic [7:0] exp_v;
    logic       exp_c;
    bit         noise;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where DONE is seen (or on timeout).
  task automatic run_op(input logic [1:0] op, input logic [2:0] cnt, input logic [7:0] val,
                        input logic cin, input bit noise, output int lat, output int busy_cyc);
    OP_SEL   = op;
    COUNT    = cnt;
    VALUE_IN = val;
    CARRY_IN = cin;
    START    = 1'b1;
    @(negedge CLK);
    START    = 1'b0;
    lat      = 1;
    busy_cyc = 0;
    while (!DONE && lat < 20) begin
      if (BUSY) begin
        busy_cyc++;
        if (noise) begin
          START    = 1'b1;
          OP_SEL   = 2'b00;
          COUNT    = 3'd0;
          VALUE_IN = 8'h3C;
          CARRY_IN = 1'b0;
        end
      end
      @(negedge CLK);
      START = 1'b0;
      lat++;
    end
    START = 1'b0;
    if (!DONE) lat = 99;
  endtask

  vec_t vecs[12];

  initial begin
    int lat;
    int bc;
    int done_seen;

    vecs[0]  = '{2'b00, 3'd1, 8'h81, 1'b0, 8'h02, 1'b1, 1'b0};
    vecs[1]  = '{2'b11, 3'd3, 8'h01, 1'b1, 8'h60, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 3'd0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[3]  = '{2'b01, 3'd0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[4]  = '{2'b10, 3'd0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[5]  = '{2'b11, 3'd0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    vecs[6]  = '{2'b01, 3'd7, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b1};
    vecs[7]  = '{2'b00, 3'd7, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 3'd1, 8'h81, 1'b0, 8'h40, 1'b1, 1'b0};
    vecs[9]  = '{2'b10, 3'd2, 8'h55, 1'b0, 8'h54, 1'b1, 1'b0};
    vecs[10] = '{2'b11, 3'd1, 8'h80, 1'b0, 8'h40, 1'b0, 1'b0};
    vecs[11] = '{2'b10, 3'd7, 8'h01, 1'b1, 8'hC0, 1'b0, 1'b1};

    RST_bar  = 1'b0;
    START    = 1'b0;
    OP_SEL   = 2'b00;
    COUNT    = 3'd0;
    VALUE_IN = 8'h00;
    CARRY_IN = 1'b0;
    repeat (2) @(negedge CLK);

    check("reset_value", 32'(VALUE_OUT), 32'h00);
    check("reset_carry", 32'(CARRY_OUT), 32'h0);
    check("reset_busy",  32'(BUSY),      32'h0);
    check("reset_done",  32'(DONE),      32'h0);

    RST_bar = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].cnt, vecs[i].val, vecs[i].cin, vecs[i].noise, lat, bc);
      check($sformatf("vec%0d_value", i),   32'(VALUE_OUT), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d_carry", i),   32'(CARRY_OUT), 32'(vecs[i].exp_c));
      check($sformatf("vec%0d_latency", i), 32'(lat),       32'(vecs[i].cnt) + 32'd1);
      check($sformatf("vec%0d_busy", i),    32'(bc),        32'(vecs[i].cnt));
      @(negedge CLK);
      check($sformatf("vec%0d_idle", i),    {30'd0, DONE, BUSY}, 32'd0);
      check($sformatf("vec%0d_hold", i),    32'({CARRY_OUT, VALUE_OUT}),
            32'({vecs[i].exp_c, vecs[i].exp_v}));
    end

    // Back-to-back: START held in FIN reloads with no IDLE cycle.
    run_op(2'b00, 3'd1, 8'h81, 1'b0, 1'b0, lat, bc);
    check("b2b_first_value", 32'(VALUE_OUT), 32'h02);
    run_op(2'b10, 3'd1, 8'h80, 1'b1, 1'b0, lat, bc);
    check("b2b_latency", 32'(lat),       32'd2);
    check("b2b_busy",    32'(bc),        32'd1);
    check("b2b_value",   32'(VALUE_OUT), 32'h01);
    check("b2b_carry",   32'(CARRY_OUT), 32'h1);
    @(negedge CLK);

    // Mid-operation reset: abort after two steps, no DONE afterwards.
    OP_SEL   = 2'b01;
    COUNT    = 3'd5;
    VALUE_IN = 8'hFF;
    CARRY_IN = 1'b0;
    START    = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("midrst_busy_before", 32'(BUSY), 32'h1);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    check("midrst_step2_value", 32'(VALUE_OUT), 32'h3F);
    RST_bar = 1'b0;
    #1;
    check("midrst_value", 32'(VALUE_OUT), 32'h00);
    check("midrst_carry", 32'(CARRY_OUT), 32'h0);
    check("midrst_busy",  32'(BUSY),      32'h0);
    check("midrst_done",  32'(DONE),      32'h0);
    @(negedge CLK);
    RST_bar   = 1'b1;
    done_seen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (DONE) done_seen++;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    check("midrst_idle_busy", 32'(BUSY), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
